mem_stage_ctrl: RTL and testbench

Memory-stage consumer of the execute/memory pipeline register: it takes the registered ALU results and memory/writeback control flags, performs scalar or vector loads and stores against a byte-wide data memory through a req/ack handshake, and delivers the result to the writeback register. Memory operations are serialized one byte-beat per accepted handshake. The block raises a stall to freeze the upstream stages while an access is in flight. Non-memory operations pass through with one cycle of latency.

---
 rtl/mem_stage_ctrl_if.sv | 25 ++
 rtl/mem_stage_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Byte-wide data memory port of the memory stage.
// The master side issues beats; the slave side acks them.
interface mem_stage_ctrl_if #(
  parameter int ADDR_BITS = 6,
  parameter int ELEM_SIZE = 8
) ();
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [ELEM_SIZE-1:0] mem_wdata_o;
  logic [ELEM_SIZE-1:0] mem_rdata_i;
  logic                 mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage: serialises scalar/vector loads and stores into
// byte beats, stalls upstream while busy, feeds writeback.
module mem_stage_ctrl #(
  parameter int REGI_SIZE  = 16,
  parameter int VECT_SIZE  = 8,
  parameter int ELEM_SIZE  = 8,
  parameter int MEMO_LINES = 64,
  parameter int ADDR_BITS  = $clog2(MEMO_LINES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [REGI_SIZE-1:0]           ialu_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
  input  logic                           enableMem_i,
  input  logic                           enableReg_i,
  input  logic                           flagMemRead_i,
  input  logic                           flagMemWrite_i,
  input  logic                           isOper1V_i,
  input  logic                           writeResultInt_i,
  input  logic                           writeResultV_i,
  mem_stage_ctrl_if.master               mem,
  output logic                           stall_o,
  output logic                           wb_valid_o,
  output logic [REGI_SIZE-1:0]           wb_ialu_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] wb_valu_o,
  output logic                           wb_enableReg_o,
  output logic                           wb_writeResultInt_o,
  output logic                           wb_writeResultV_o
);
  localparam int VW = ELEM_SIZE * VECT_SIZE;
  localparam int CW = $clog2(VECT_SIZE) + 1;
  localparam logic [CW-1:0] NVEC = CW'(VECT_SIZE);
  localparam logic [CW-1:0] NSCA = CW'(REGI_SIZE / ELEM_SIZE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        beat_q, beat_d;
  logic [CW-1:0]        n_q;
  logic [ADDR_BITS-1:0] base_q;
  logic [REGI_SIZE-1:0] ialu_q;
  logic [VW-1:0]        valu_q;
  logic [VW-1:0]        asm_q, asm_d;
  logic                 we_q, vld_q;
  logic                 er_q, wi_q, wv_q;

  logic          mem_op, vec_op, busy, ack_hit, last;
  logic [CW-1:0] n_beats;

  assign mem_op  = enableMem_i & (flagMemRead_i | flagMemWrite_i);
  assign vec_op  = (flagMemRead_i & writeResultV_i)
                 | (flagMemWrite_i & isOper1V_i);
  assign n_beats = vec_op ? NVEC : NSCA;
  assign busy    = (state_q == BUSY);
  assign ack_hit = busy & mem.mem_ack_i;
  assign last    = (beat_q == n_q - CW'(1));

  assign mem.mem_req_o   = busy;
  assign mem.mem_we_o    = busy & we_q;
  assign mem.mem_addr_o  = busy ? base_q + ADDR_BITS'(beat_q) : '0;
  assign mem.mem_wdata_o = busy
    ? valu_q[int'(beat_q)*ELEM_SIZE +: ELEM_SIZE] : '0;

  assign stall_o = rst_i & (((state_q == IDLE) & mem_op)
                 | (busy & !(mem.mem_ack_i & last)));

  // next state, beat counter and load assembly merge
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = BUSY;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (mem.mem_ack_i) begin
          if (!we_q)
            asm_d[int'(beat_q)*ELEM_SIZE +: ELEM_SIZE] =
              mem.mem_rdata_i;
          if (last) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and beat counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // capture the operation when it is accepted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_q <= '0;
      ialu_q <= '0;
      valu_q <= '0;
      n_q    <= '0;
      we_q   <= 1'b0;
      vld_q  <= 1'b0;
      er_q   <= 1'b0;
      wi_q   <= 1'b0;
      wv_q   <= 1'b0;
      asm_q  <= '0;
    end else if (!busy && mem_op) begin
      base_q <= ialu_res_i[ADDR_BITS-1:0];
      ialu_q <= ialu_res_i;
      valu_q <= valu_res_i;
      n_q    <= n_beats;
      we_q   <= flagMemWrite_i;
      vld_q  <= !flagMemWrite_i & writeResultV_i;
      er_q   <= enableReg_i;
      wi_q   <= writeResultInt_i;
      wv_q   <= writeResultV_i;
      asm_q  <= '0;
    end else begin
      asm_q  <= asm_d;
    end
  end

  // writeback register: pass-through, bubble, or access result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_o          <= 1'b0;
      wb_ialu_o           <= '0;
      wb_valu_o           <= '0;
      wb_enableReg_o      <= 1'b0;
      wb_writeResultInt_o <= 1'b0;
      wb_writeResultV_o   <= 1'b0;
    end else if (!busy) begin
      if (mem_op) begin
        wb_valid_o <= 1'b0;
      end else begin
        wb_valid_o          <= enableReg_i | enableMem_i;
        wb_ialu_o           <= ialu_res_i;
        wb_valu_o           <= valu_res_i;
        wb_enableReg_o      <= enableReg_i;
        wb_writeResultInt_o <= writeResultInt_i;
        wb_writeResultV_o   <= writeResultV_i;
      end
    end else if (ack_hit && last) begin
      wb_valid_o          <= 1'b1;
      wb_ialu_o           <= (!we_q && !vld_q)
                           ? asm_d[REGI_SIZE-1:0] : ialu_q;
      wb_valu_o           <= (!we_q && vld_q) ? asm_d : valu_q;
      wb_enableReg_o      <= er_q;
      wb_writeResultInt_o <= wi_q;
      wb_writeResultV_o   <= wv_q;
    end else begin
      wb_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected beats and
// writeback entries are queued, a negedge monitor checks them.
module tb_mem_stage_ctrl;
  localparam int RS = 16;
  localparam int ES = 8;
  localparam int AB = 6;
  localparam int VW = 64;

  typedef struct {
    logic [AB-1:0] addr;
    logic          we;
    logic [ES-1:0] wdata;
  } beat_t;

  typedef struct {
    logic [RS-1:0] ialu;
    logic [VW-1:0] valu;
    logic          er;
    logic          wi;
    logic          wv;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [RS-1:0] ialu_res;
  logic [VW-1:0] valu_res;
  logic en_mem, en_reg, rd, wr, v1, wri, wrv;
  logic stall, wb_valid, wb_er, wb_wi, wb_wv;
  logic [RS-1:0] wb_ialu;
  logic [VW-1:0] wb_valu;
  logic ack;
  logic poke_en;
  logic [AB-1:0] poke_a;
  logic [ES-1:0] poke_d;
  logic [ES-1:0] mem_m [64];

  beat_t bq[$];
  wb_t   wq[$];
  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.ADDR_BITS(AB), .ELEM_SIZE(ES)) bus ();

  assign bus.mem_ack_i   = ack;
  assign bus.mem_rdata_i = mem_m[bus.mem_addr_o];

  mem_stage_ctrl dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .ialu_res_i          (ialu_res),
    .valu_res_i          (valu_res),
    .enableMem_i         (en_mem),
    .enableReg_i         (en_reg),
    .flagMemRead_i       (rd),
    .flagMemWrite_i      (wr),
    .isOper1V_i          (v1),
    .writeResultInt_i    (wri),
    .writeResultV_i      (wrv),
    .mem                 (bus),
    .stall_o             (stall),
    .wb_valid_o          (wb_valid),
    .wb_ialu_o           (wb_ialu),
    .wb_valu_o           (wb_valu),
    .wb_enableReg_o      (wb_er),
    .wb_writeResultInt_o (wb_wi),
    .wb_writeResultV_o   (wb_wv)
  );

  // memory model: preload pokes or acked store beats
  always @(posedge clk) begin
    if (poke_en)
      mem_m[poke_a] <= poke_d;
    else if (bus.mem_req_o && ack && bus.mem_we_o)
      mem_m[bus.mem_addr_o] <= bus.mem_wdata_o;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: compare beats and writeback entries
  always @(negedge clk) begin
    wb_t e;
    if (stall) stall_cnt++;
    if (bus.mem_req_o) begin
      if (bq.size() == 0) begin
        chk("beat_unexpected", 64'(bus.mem_req_o), 0);
      end else begin
        chk("beat_addr", 64'(bus.mem_addr_o), 64'(bq[0].addr));
        chk("beat_we", 64'(bus.mem_we_o), 64'(bq[0].we));
        if (bq[0].we)
          chk("beat_wdata", 64'(bus.mem_wdata_o),
              64'(bq[0].wdata));
        if (ack) void'(bq.pop_front());
      end
    end
    if (wb_valid) begin
      if (wq.size() == 0) begin
        chk("wb_unexpected", 64'(wb_valid), 0);
      end else begin
        e = wq.pop_front();
        chk("wb_ialu", 64'(wb_ialu), 64'(e.ialu));
        chk("wb_valu", wb_valu, e.valu);
        chk("wb_er", 64'(wb_er), 64'(e.er));
        chk("wb_wi", 64'(wb_wi), 64'(e.wi));
        chk("wb_wv", 64'(wb_wv), 64'(e.wv));
      end
    end
  end

  task automatic poke(input logic [AB-1:0] a, input logic [ES-1:0] d);
    @(posedge clk); #1;
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic pb(input logic [AB-1:0] a, input logic w,
                    input logic [ES-1:0] d);
    beat_t b;
    b.addr = a; b.we = w; b.wdata = d;
    bq.push_back(b);
  endtask

  task automatic pw(input logic [RS-1:0] ia, input logic [VW-1:0] va,
                    input logic er, input logic wi, input logic wv);
    wb_t e;
    e.ialu = ia; e.valu = va; e.er = er; e.wi = wi; e.wv = wv;
    wq.push_back(e);
  endtask

  task automatic set_in(input logic [RS-1:0] ia, input logic [VW-1:0] va,
                        input logic em, input logic er, input logic r,
                        input logic w, input logic o1, input logic wi,
                        input logic wv);
    ialu_res = ia; valu_res = va;
    en_mem = em; en_reg = er; rd = r; wr = w;
    v1 = o1; wri = wi; wrv = wv;
  endtask

  task automatic clr_in();
    set_in('0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_op(input string nm,
                        input logic [RS-1:0] ia, input logic [VW-1:0] va,
                        input logic em, input logic er, input logic r,
                        input logic w, input logic o1, input logic wi,
                        input logic wv, input int waits,
                        input int exp_stall);
    int wcnt = 0;
    int cyc = 0;
    bit done = 0;
    @(posedge clk); #1;
    set_in(ia, va, em, er, r, w, o1, wi, wv);
    ack = (waits == 0);
    stall_cnt = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        @(posedge clk); #1;
        if (bus.mem_req_o) begin
          if (wcnt < waits) begin
            ack = 1'b0;
            wcnt++;
          end else begin
            ack = 1'b1;
          end
        end
        cyc++;
      end
    end
    if (!done) chk({nm, "_timeout"}, 64'(stall), 0);
    @(posedge clk); #1;
    clr_in();
    ack = 1'b1;
    @(negedge clk);
    chk({nm, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    ack = 1'b1;
    poke_en = 1'b0;
    poke_a = '0;
    poke_d = '0;
    for (int i = 0; i < 8; i++)
      poke(AB'(62 + i), ES'(i + 1));
    poke(6'h20, 8'h34);
    poke(6'h21, 8'h12);
    poke(6'h30, 8'h55);
    poke(6'h31, 8'h66);

    @(negedge clk);
    chk("rst_req", 64'(bus.mem_req_o), 0);
    chk("rst_we", 64'(bus.mem_we_o), 0);
    chk("rst_addr", 64'(bus.mem_addr_o), 0);
    chk("rst_wdata", 64'(bus.mem_wdata_o), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_wb_ialu", 64'(wb_ialu), 0);
    chk("rst_wb_valu", wb_valu, 0);
    chk("rst_wb_flags", {61'd0, wb_er, wb_wi, wb_wv}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // vector load interrupted by reset during beat 3
    pb(6'd62, 0, 0); pb(6'd63, 0, 0); pb(6'd0, 0, 0);
    @(posedge clk); #1;
    set_in(16'hAB3E, '1, 1, 1, 1, 0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_pre_req", 64'(bus.mem_req_o), 1);
    chk("midrst_pre_addr", 64'(bus.mem_addr_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 64'(bus.mem_req_o), 0);
    chk("midrst_we", 64'(bus.mem_we_o), 0);
    chk("midrst_addr", 64'(bus.mem_addr_o), 0);
    chk("midrst_wdata", 64'(bus.mem_wdata_o), 0);
    chk("midrst_stall", 64'(stall), 0);
    chk("midrst_wb", {wb_valu[59:0], wb_valid, wb_er, wb_wi, wb_wv}, 0);
    clr_in();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall), 0);
    chk("post_rst_req", 64'(bus.mem_req_o), 0);
    chk("post_rst_beats_left", 64'(bq.size()), 0);

    // scalar store, ack always high
    pb(6'h10, 1, 8'hEF); pb(6'h11, 1, 8'hBE);
    pw(16'h0010, 64'h0000_0000_0000_BEEF, 0, 0, 0);
    run_op("sst", 16'h0010, 64'h0000_0000_0000_BEEF,
           1, 0, 0, 1, 0, 0, 0, 0, 2);

    // vector load wrapping from 63 to 0
    for (int i = 0; i < 8; i++) pb(AB'(62 + i), 0, 0);
    pw(16'hAB3E, 64'h0807_0605_0403_0201, 1, 0, 1);
    run_op("vld", 16'hAB3E, 64'hFFFF_FFFF_FFFF_FFFF,
           1, 1, 1, 0, 0, 0, 1, 0, 8);

    // scalar load, three wait states on beat 0
    pb(6'h20, 0, 0); pb(6'h21, 0, 0);
    pw(16'h1234, 64'h0123_4567_89AB_CDEF, 1, 1, 0);
    run_op("sld_wait", 16'h0020, 64'h0123_4567_89AB_CDEF,
           1, 1, 1, 0, 0, 1, 0, 3, 5);

    // non-memory pass-through stream
    pw(16'h1234, 64'h1111, 1, 1, 0);
    run_op("alu0", 16'h1234, 64'h1111, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    pw(16'h5678, 64'h2222, 1, 1, 0);
    run_op("alu1", 16'h5678, 64'h2222, 0, 1, 0, 0, 0, 1, 0, 0, 0);

    // read and write both set: a store
    pb(6'h30, 1, 8'hFE); pb(6'h31, 1, 8'hCA);
    pw(16'h0030, 64'h0000_0000_0000_CAFE, 1, 1, 0);
    run_op("rw_both", 16'h0030, 64'h0000_0000_0000_CAFE,
           1, 1, 1, 1, 0, 1, 0, 0, 2);

    // vector store wrapping, then read it back
    pb(6'd60, 1, 8'h88); pb(6'd61, 1, 8'h77);
    pb(6'd62, 1, 8'h66); pb(6'd63, 1, 8'h55);
    pb(6'd0, 1, 8'h44); pb(6'd1, 1, 8'h33);
    pb(6'd2, 1, 8'h22); pb(6'd3, 1, 8'h11);
    pw(16'h003C, 64'h1122_3344_5566_7788, 0, 0, 0);
    run_op("vst", 16'h003C, 64'h1122_3344_5566_7788,
           1, 0, 0, 1, 1, 0, 0, 0, 8);
    for (int i = 0; i < 8; i++) pb(AB'(60 + i), 0, 0);
    pw(16'h003C, 64'h1122_3344_5566_7788, 1, 0, 1);
    run_op("vld_back", 16'h003C, 64'h0,
           1, 1, 1, 0, 0, 0, 1, 0, 8);

    repeat (3) @(negedge clk);
    chk("beats_left", 64'(bq.size()), 0);
    chk("wb_left", 64'(wq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
